sync_fifo_v2: RTL

Parametrised single-clock FIFO, successor to the current FIFO_TOP. Adds a selectable first-word-fall-through read mode, an occupancy count output, read/write pass-through when full, and sticky overflow/underflow error flags with a clear input. It sits between any two same-clock producer/consumer blocks in the design and keeps the existing almost-full/almost-empty thresholds.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 27 ++
 rtl/sync_fifo_v2.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo_v2 FIFO and its bench.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam int MAX_ADDR_WIDTH = 30;

  // Clamp the width so the shift cannot run past a 32-bit int.
  function automatic int fifo_depth(input int addr_width);
    int aw;
    aw = (addr_width > MAX_ADDR_WIDTH) ? MAX_ADDR_WIDTH :
         (addr_width < 0) ? 0 : addr_width;
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Contents are deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with optional first-word fall-through, occupancy count,
// full-state read/write pass-through and sticky overflow/underflow flags.
module sync_fifo_v2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH              = 8,
  parameter int ADDR_WIDTH              = 4,
  parameter int ALMOST_FULL_LEFT_SLOTS  = 4,
  parameter int ALMOST_EMPTY_AVAI_SLOTS = 4,
  parameter bit FWFT                    = 1'b0
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  WR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL_FLAG,
  output logic                  ALMOST_EMPTY_FLAG,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  input  logic                  CLR_ERR
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] DEPTH_LEVEL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LEVEL    = PW'(DEPTH - ALMOST_FULL_LEFT_SLOTS);
  localparam logic [PW-1:0] AE_LEVEL    = PW'(ALMOST_EMPTY_AVAI_SLOTS);

  if (ALMOST_FULL_LEFT_SLOTS < 0 || ALMOST_FULL_LEFT_SLOTS >= DEPTH) begin : g_bad_af
    $error("sync_fifo_v2: ALMOST_FULL_LEFT_SLOTS must be in 0..DEPTH-1");
  end
  if (ALMOST_EMPTY_AVAI_SLOTS < 0 || ALMOST_EMPTY_AVAI_SLOTS >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_v2: ALMOST_EMPTY_AVAI_SLOTS must be in 0..DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] head_data;
  fifo_status_t          status;

  // The extra MSB on each pointer tells full from empty when the addresses match.
  assign count = wr_ptr - rd_ptr;

  always_comb begin
    status              = '0;
    status.full         = (count == DEPTH_LEVEL);
    status.empty        = (count == '0);
    status.almost_full  = (count >= AF_LEVEL);
    status.almost_empty = (count <= AE_LEVEL);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_acc = RD && !status.empty;
  assign wr_acc = WR && (!status.full || rd_acc);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (WR && !wr_acc)   overflow_q <= 1'b1;
      else if (CLR_ERR)    overflow_q <= 1'b0;
      if (RD && !rd_acc)   underflow_q <= 1'b1;
      else if (CLR_ERR)    underflow_q <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (i_CLK),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (WR_DATA),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (head_data)
  );

  if (FWFT) begin : g_fwft
    assign RD_DATA  = head_data;
    assign RD_VALID = !status.empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= head_data;
      end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
  end

  assign FULL              = status.full;
  assign EMPTY             = status.empty;
  assign ALMOST_FULL_FLAG  = status.almost_full;
  assign ALMOST_EMPTY_FLAG = status.almost_empty;
  assign OVERFLOW          = status.overflow;
  assign UNDERFLOW         = status.underflow;
  assign COUNT             = count;

endmodule
